// File: rtl/pong_game_sequencer.sv
// Pong game sequencer: frame divider, serve/rally/point flow and scorekeeping.
// Drives the ball/paddle engine with per-frame step pulses and a serve hold.
module pong_game_sequencer #(
  parameter int FRAME_DIV   = 4,
  parameter int SERVE_DELAY = 3,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       engine_step,
  output logic       engine_serve,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RALLY     = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [3:0] SERVE_LAST = 4'(SERVE_DELAY - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     cur;
  logic [7:0] div_cnt;
  logic [3:0] serve_cnt;
  logic       div_last;
  logic       frame_tick;
  logic       any_miss;
  logic       scorer_won;

  assign div_last   = (div_cnt == DIV_LAST);
  assign frame_tick = div_last && !pause;
  assign any_miss   = miss_left || miss_right;
  // serve_dir points at the player who just lost the point, so it names the scorer
  assign scorer_won = serve_dir ? (score_left == WIN) : (score_right == WIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      div_cnt     <= '0;
      serve_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      if (!pause) begin
        div_cnt <= div_last ? '0 : div_cnt + 8'd1;
      end

      case (cur)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            cur         <= S_SERVE;
            div_cnt     <= '0;
            serve_cnt   <= '0;
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
          end
        end

        S_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              cur     <= S_RALLY;
              div_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 4'd1;
            end
          end
        end

        S_RALLY: begin
          if (miss_left && miss_right) begin
            // Simultaneous misses: replay the serve, nobody scores
            cur       <= S_SERVE;
            div_cnt   <= '0;
            serve_cnt <= '0;
          end else if (miss_left) begin
            if (score_right != WIN) begin
              score_right <= score_right + 4'd1;
            end
            serve_dir <= 1'b0;
            cur       <= S_POINT;
            div_cnt   <= '0;
          end else if (miss_right) begin
            if (score_left != WIN) begin
              score_left <= score_left + 4'd1;
            end
            serve_dir <= 1'b1;
            cur       <= S_POINT;
            div_cnt   <= '0;
          end
        end

        S_POINT: begin
          div_cnt <= '0;
          if (scorer_won) begin
            cur    <= S_GAME_OVER;
            winner <= ~serve_dir;
          end else begin
            cur       <= S_SERVE;
            serve_cnt <= '0;
          end
        end

        default: begin
          cur     <= S_IDLE;
          div_cnt <= '0;
        end
      endcase
    end
  end

  assign state        = cur;
  assign game_over    = (cur == S_GAME_OVER);
  assign engine_serve = (cur == S_SERVE) || (cur == S_POINT) || (cur == S_GAME_OVER);
  // A miss pre-empts the step that would otherwise fire on the same frame tick
  assign engine_step  = (cur == S_RALLY) && frame_tick && !any_miss;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed table, corner sequences and random
// stimulus against a cycle-accounting reference model (two WIN_SCORE settings).
module tb_pong_game_sequencer;

  localparam int FD = 4;
  localparam int SD = 3;
  localparam int W1 = 7;
  localparam int W2 = 2;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, pause, miss_left, miss_right;

  logic       a_step, a_serve, a_dir, a_go, a_win;
  logic [3:0] a_sl, a_sr;
  logic [2:0] a_state;
  logic       b_step, b_serve, b_dir, b_go, b_win;
  logic [3:0] b_sl, b_sr;
  logic [2:0] b_state;

  pong_game_sequencer #(.FRAME_DIV(FD), .SERVE_DELAY(SD), .WIN_SCORE(W1)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .miss_left(miss_left), .miss_right(miss_right),
    .engine_step(a_step), .engine_serve(a_serve), .serve_dir(a_dir),
    .score_left(a_sl), .score_right(a_sr), .state(a_state),
    .game_over(a_go), .winner(a_win)
  );

  pong_game_sequencer #(.FRAME_DIV(FD), .SERVE_DELAY(SD), .WIN_SCORE(W2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .miss_left(miss_left), .miss_right(miss_right),
    .engine_step(b_step), .engine_serve(b_serve), .serve_dir(b_dir),
    .score_left(b_sl), .score_right(b_sr), .state(b_state),
    .game_over(b_go), .winner(b_win)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase uses the externally visible state numbering; 'active' counts the
  // unpaused cycles spent in the current phase, from which frame timing follows.
  typedef struct {
    int ph;
    int active;
    int sl;
    int sr;
    int dir;
    int win;
  } ms_t;

  ms_t m1, m2;

  function automatic ms_t mdl_reset();
    ms_t n;
    n.ph = 0; n.active = 0; n.sl = 0; n.sr = 0; n.dir = 0; n.win = 0;
    return n;
  endfunction

  function automatic int mdl_step(ms_t m, bit p, bit ml, bit mr);
    return (m.ph == 2 && !p && (m.active % FD) == FD - 1 && !ml && !mr) ? 1 : 0;
  endfunction

  function automatic ms_t mdl_next(ms_t m, int w, bit r, bit s, bit p, bit ml, bit mr);
    ms_t n;
    int  nph;
    if (r) return mdl_reset();
    n   = m;
    nph = m.ph;
    case (m.ph)
      0, 4: if (s) begin
        nph = 1; n.sl = 0; n.sr = 0; n.dir = 0; n.win = 0;
      end
      1: if (!p && m.active == SD * FD - 1) nph = 2;
      2: begin
        if (ml && mr) nph = 1;
        else if (ml) begin n.sr = n.sr + 1; n.dir = 0; nph = 3; end
        else if (mr) begin n.sl = n.sl + 1; n.dir = 1; nph = 3; end
      end
      3: begin
        if (n.sl == w || n.sr == w) begin
          nph   = 4;
          n.win = (n.sr == w) ? 1 : 0;
        end else begin
          nph = 1;
        end
      end
      default: nph = 0;
    endcase
    n.active = (nph != m.ph) ? 0 : (p ? m.active : m.active + 1);
    n.ph     = nph;
    return n;
  endfunction

  task automatic cmp_dut(input string tag, input ms_t m, input bit p, input bit ml, input bit mr,
                         input logic [2:0] st, input logic stp, input logic srv, input logic dir,
                         input logic [3:0] sl, input logic [3:0] sr, input logic go, input logic win);
    chk({tag, ".state"}, int'(st), m.ph);
    chk({tag, ".engine_step"}, int'(stp), mdl_step(m, p, ml, mr));
    chk({tag, ".engine_serve"}, int'(srv), (m.ph == 1 || m.ph == 3 || m.ph == 4) ? 1 : 0);
    chk({tag, ".serve_dir"}, int'(dir), m.dir);
    chk({tag, ".score_left"}, int'(sl), m.sl);
    chk({tag, ".score_right"}, int'(sr), m.sr);
    chk({tag, ".game_over"}, int'(go), (m.ph == 4) ? 1 : 0);
    if (m.ph == 4) chk({tag, ".winner"}, int'(win), m.win);
  endtask

  // ---------------- driver tasks ----------------
  // drive(): apply inputs at the falling edge, compare both DUTs with the model.
  // adv(): take the rising edge, advance the models, return to the falling edge.
  task automatic drive(input bit r, input bit s, input bit p, input bit ml, input bit mr);
    reset = r; start = s; pause = p; miss_left = ml; miss_right = mr;
    #1;
    cmp_dut("w7", m1, p, ml, mr, a_state, a_step, a_serve, a_dir, a_sl, a_sr, a_go, a_win);
    cmp_dut("w2", m2, p, ml, mr, b_state, b_step, b_serve, b_dir, b_sl, b_sr, b_go, b_win);
  endtask

  task automatic adv();
    @(posedge clk);
    m1 = mdl_next(m1, W1, reset, start, pause, miss_left, miss_right);
    m2 = mdl_next(m2, W2, reset, start, pause, miss_left, miss_right);
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit ml, input bit mr);
    drive(r, s, p, ml, mr);
    adv();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic to_rally();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(SD * FD);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         st, ps, ml, mr;
    logic [2:0] e_state;
    logic       e_step, e_serve, e_dir;
    logic [3:0] e_sl, e_sr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit st, input bit ps, input bit ml, input bit mr,
                         input logic [2:0] es, input logic estp, input logic esrv,
                         input logic edir, input logic [3:0] esl, input logic [3:0] esr);
    vec_t v;
    v.st = st; v.ps = ps; v.ml = ml; v.mr = mr;
    v.e_state = es; v.e_step = estp; v.e_serve = esrv; v.e_dir = edir;
    v.e_sl = esl; v.e_sr = esr;
    vecs.push_back(v);
  endtask

  int steps;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (2) @(posedge clk);
    m1 = mdl_reset();
    m2 = mdl_reset();
    @(negedge clk);

    // Reset state
    drive(0, 0, 0, 0, 0);
    chk("reset.state", int'(a_state), 0);
    chk("reset.winner", int'(a_win), 0);
    chk("reset.serve", int'(a_serve), 0);
    chk("reset.scores", int'({a_sl, a_sr}), 0);
    adv();

    // Start, 12-cycle serve, steps every 4 cycles, miss on a tick cycle
    add_vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < SD * FD; i++) add_vec(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 3, 0, 1, 1, 1, 0);
    add_vec(0, 0, 0, 0, 1, 0, 1, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].st, vecs[i].ps, vecs[i].ml, vecs[i].mr);
      chk($sformatf("vec%0d.state", i), int'(a_state), int'(vecs[i].e_state));
      chk($sformatf("vec%0d.step", i), int'(a_step), int'(vecs[i].e_step));
      chk($sformatf("vec%0d.serve", i), int'(a_serve), int'(vecs[i].e_serve));
      chk($sformatf("vec%0d.dir", i), int'(a_dir), int'(vecs[i].e_dir));
      chk($sformatf("vec%0d.sl", i), int'(a_sl), int'(vecs[i].e_sl));
      chk($sformatf("vec%0d.sr", i), int'(a_sr), int'(vecs[i].e_sr));
      adv();
    end

    // Pause mid-rally: no steps while paused, then the remaining phase
    to_rally();
    idle(2);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, 0);
      steps += int'(a_step);
      adv();
    end
    chk("pause.steps", steps, 0);
    drive(0, 0, 0, 0, 0);
    chk("pause.resume0", int'(a_step), 0);
    adv();
    drive(0, 0, 0, 0, 0);
    chk("pause.resume1", int'(a_step), 1);
    chk("pause.state", int'(a_state), 2);
    adv();

    // Double miss: back to serve, scores and serve_dir untouched
    to_rally();
    cyc(0, 0, 0, 0, 1);
    idle(1 + SD * FD);
    drive(0, 0, 0, 1, 1);
    chk("dbl.step", int'(a_step), 0);
    adv();
    drive(0, 0, 0, 0, 0);
    chk("dbl.state", int'(a_state), 1);
    chk("dbl.sl", int'(a_sl), 1);
    chk("dbl.sr", int'(a_sr), 0);
    chk("dbl.dir", int'(a_dir), 1);
    adv();

    // WIN_SCORE=2 instance: two left misses end the game, start restarts
    to_rally();
    cyc(0, 0, 0, 1, 0);
    idle(1 + SD * FD);
    cyc(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("win.point_state", int'(b_state), 3);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, i[0], 1, i[1]);
      chk("win.state", int'(b_state), 4);
      chk("win.sr", int'(b_sr), 2);
      chk("win.game_over", int'(b_go), 1);
      chk("win.winner", int'(b_win), 1);
      adv();
    end
    cyc(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("win.restart_state", int'(b_state), 1);
    chk("win.restart_sr", int'(b_sr), 0);
    chk("win.restart_go", int'(b_go), 0);
    adv();

    // Reset mid-serve
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(5);
    cyc(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_serve.state", int'(a_state), 0);
    adv();

    // Reset mid-rally with score_left=3, then misses in IDLE are ignored
    to_rally();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1);
      idle(1 + SD * FD);
    end
    drive(0, 0, 0, 0, 0);
    chk("rst_rally.pre_sl", int'(a_sl), 3);
    adv();
    cyc(1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_rally.state", int'(a_state), 0);
    chk("rst_rally.sl", int'(a_sl), 0);
    chk("rst_rally.outs", int'({a_step, a_serve, a_dir, a_go, a_win}), 0);
    adv();
    for (int i = 0; i < 3; i++) cyc(0, 0, i[0], 1, i[1]);
    drive(0, 0, 0, 0, 0);
    chk("idle_miss.scores", int'({a_sl, a_sr}), 0);
    adv();

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
